// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum bar renderer: colour codes, pipeline
// latency and a constant clog2 helper.
package spectrum_pkg;

    typedef logic [5:0] colour_t;   // {R[1:0], G[1:0], B[1:0]}

    localparam int unsigned OUT_LATENCY = 2;

    localparam colour_t BLACK            = 6'b000000;
    localparam colour_t DEF_BAR_COLOR    = 6'b001100;
    localparam colour_t DEF_BG_COLOR     = 6'b000011;
    localparam colour_t DEF_AREA_COLOR   = 6'b110000;
    localparam colour_t DEF_PEAK_COLOR   = 6'b111100;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spectrum_peak_store.sv
// Per-bin peak-hold registers with frame-counted decay; built only when
// PEAK_HOLD_EN is defined.
module spectrum_peak_store
    import spectrum_pkg::*;
#(
    parameter int unsigned BINS         = 64,
    parameter int unsigned MAG_W        = 8,
    parameter int unsigned DECAY_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     upd_en,
    input  logic [clog2(BINS)-1:0]   bin,
    input  logic [MAG_W-1:0]         data,
    output logic [MAG_W-1:0]         peak
);

    localparam int unsigned BIN_W = clog2(BINS);
    localparam int unsigned CNT_W = (clog2(DECAY_FRAMES) < 1) ? 1 : clog2(DECAY_FRAMES);

    logic [MAG_W-1:0] peaks      [BINS];
    logic [MAG_W-1:0] peaks_next [BINS];
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = frame_start && (cnt == CNT_W'(DECAY_FRAMES - 1));
    assign peak = peaks[bin];

    // Decay is applied first so a same-cycle update compares against the decremented value.
    always_comb begin
        for (int unsigned i = 0; i < BINS; i++) begin
            peaks_next[i] = peaks[i];
            if (wrap && peaks[i] != '0) begin
                peaks_next[i] = peaks[i] - 1'b1;
            end
            if (upd_en && bin == BIN_W'(i) && data > peaks_next[i]) begin
                peaks_next[i] = data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            peaks <= '{default: '0};
        end else begin
            if (frame_start) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
            end
            peaks <= peaks_next;
        end
    end

endmodule

// File: rtl/spectrum_bar_renderer.sv
// Two-stage raster renderer drawing BINS magnitude bars from a RAM.
// Optional peak-hold markers are built when the PEAK_HOLD_EN macro is defined.
module spectrum_bar_renderer
    import spectrum_pkg::*;
#(
    parameter int unsigned BINS         = 64,
    parameter int unsigned BAR_W        = 8,
    parameter int unsigned GAP          = 1,
    parameter int unsigned MAG_W        = 8,
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned BASE_Y       = 470,
    parameter colour_t     BAR_COLOR    = DEF_BAR_COLOR,
    parameter colour_t     BG_COLOR     = DEF_BG_COLOR,
    parameter colour_t     AREA_COLOR   = DEF_AREA_COLOR,
    parameter colour_t     PEAK_COLOR   = DEF_PEAK_COLOR,
    parameter int unsigned PEAK_H       = 2,
    parameter int unsigned DECAY_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [9:0]        X_PIX,
    input  logic [9:0]        Y_PIX,
    input  logic              Video_On,
    input  logic [MAG_W-1:0]  data,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        R,
    output logic [1:0]        G,
    output logic [1:0]        B
);

    localparam int unsigned BIN_W = clog2(BINS);
    localparam int unsigned OFS_W = clog2(BAR_W);
    localparam logic signed [10:0] BASE = 11'(BASE_Y);

    logic [OFS_W-1:0] ofs;
    logic [BIN_W-1:0] bin;
    logic             in_area;
    logic             is_gap;

    logic [BIN_W-1:0] bin_q;
    logic [9:0]       y_q;
    logic             von_q, area_q, gap_q, first_q;

    logic signed [10:0] y_s, thr;
    logic               bar_hit, peak_hit;
    colour_t            next_rgb, rgb;

    assign ofs     = X_PIX[OFS_W-1:0];
    assign bin     = X_PIX[OFS_W +: BIN_W];
    assign in_area = {1'b0, X_PIX} < 11'(BINS * BAR_W);
    assign is_gap  = 32'(ofs) >= (BAR_W - GAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address <= '0;
            bin_q   <= '0;
            y_q     <= '0;
            von_q   <= 1'b0;
            area_q  <= 1'b0;
            gap_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            address <= (Video_On && in_area) ? ADDR_W'(bin) : '0;
            bin_q   <= bin;
            y_q     <= Y_PIX;
            von_q   <= Video_On;
            area_q  <= in_area;
            gap_q   <= is_gap;
            first_q <= (ofs == '0);
        end
    end

`ifdef PEAK_HOLD_EN
    logic [MAG_W-1:0]   peak;
    logic signed [10:0] pt;

    spectrum_peak_store #(
        .BINS         (BINS),
        .MAG_W        (MAG_W),
        .DECAY_FRAMES (DECAY_FRAMES)
    ) u_peak_store (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .upd_en       (von_q && area_q && first_q),
        .bin          (bin_q),
        .data         (data),
        .peak         (peak)
    );

    always_comb begin
        pt = BASE - $signed(11'(peak));
        if (pt < 0) begin
            pt = '0;
        end
        peak_hit = (peak != '0) && (y_s <= pt) && (y_s > pt - $signed(11'(PEAK_H)));
    end
`else
    logic unused_peak;
    assign unused_peak = ^{frame_start, first_q};
    assign peak_hit    = 1'b0;
`endif

    // Threshold is clamped at 0 so oversized magnitudes light the full column.
    always_comb begin
        y_s = $signed({1'b0, y_q});
        thr = BASE - $signed(11'(data));
        if (thr < 0) begin
            thr = '0;
        end
        bar_hit = (y_s > thr) && (y_s <= BASE);

        next_rgb = BG_COLOR;
        if (!von_q) begin
            next_rgb = BLACK;
        end else if (!area_q) begin
            next_rgb = AREA_COLOR;
        end else if (gap_q) begin
            next_rgb = BG_COLOR;
        end else if (peak_hit) begin
            next_rgb = PEAK_COLOR;
        end else if (bar_hit) begin
            next_rgb = BAR_COLOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb <= BLACK;
        end else begin
            rgb <= next_rgb;
        end
    end

    assign {R, G, B} = rgb;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Randomized self-checking bench for spectrum_bar_renderer against a
// per-pixel reference model; two instances cover BASE_Y 470 and 200.
module tb_spectrum_bar_renderer;

    localparam int DECAY_FRAMES = 4;
    localparam int C_BAR  = 6'b001100;
    localparam int C_BG   = 6'b000011;
    localparam int C_AREA = 6'b110000;
    localparam int C_PEAK = 6'b111100;
`ifdef PEAK_HOLD_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] x_pix = '0;
    logic [9:0] y_pix = '0;
    logic       video_on = 1'b0;
    logic [7:0] data_a, data_b;
    logic [8:0] address_a, address_b;
    logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [7:0] mem [512];

    int checks = 0;
    int failures = 0;
    int pk [64];
    int dcnt = 0;
    int prev_x = 0, prev_y = 0;
    bit prev_v = 1'b0;

    always #5 clk = ~clk;

    assign data_a = mem[address_a];
    assign data_b = mem[address_b];

    spectrum_bar_renderer u_dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .X_PIX(x_pix), .Y_PIX(y_pix), .Video_On(video_on),
        .data(data_a), .address(address_a), .R(r_a), .G(g_a), .B(b_a)
    );

    spectrum_bar_renderer #(.BASE_Y(200)) u_dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .X_PIX(x_pix), .Y_PIX(y_pix), .Video_On(video_on),
        .data(data_b), .address(address_b), .R(r_b), .G(g_b), .B(b_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_colour(input int px, input int py, input bit pv,
                                      input int mag, input int pkv, input int base);
        int thr, pt;
        if (!pv) return 0;
        if (px >= 512) return C_AREA;
        if (px % 8 >= 7) return C_BG;
        if (py > base) return C_BG;
        if (PEAK_ON && pkv > 0) begin
            pt = (base - pkv < 0) ? 0 : base - pkv;
            if (py <= pt && py > pt - 2) return C_PEAK;
        end
        thr = (base - mag < 0) ? 0 : base - mag;
        return (py > thr) ? C_BAR : C_BG;
    endfunction

    task automatic model_reset();
        prev_v = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 64; i++) pk[i] = 0;
    endtask

    // Drive one pixel, then check the pixel of the previous cycle on the RGB pins.
    task automatic step(input int xi, input int yi, input bit vi, input bit fsi);
        int eb, mag, pv, ea;
        x_pix = 10'(xi); y_pix = 10'(yi); video_on = vi; frame_start = fsi;
        @(posedge clk); #1;
        eb = 0; mag = 0; pv = 0;
        if (prev_v && prev_x < 512) begin
            eb = prev_x / 8; mag = int'(mem[eb]); pv = pk[eb];
        end
        check("rgb_base470", int'({r_a, g_a, b_a}), exp_colour(prev_x, prev_y, prev_v, mag, pv, 470));
        check("rgb_base200", int'({r_b, g_b, b_b}), exp_colour(prev_x, prev_y, prev_v, mag, pv, 200));
        ea = (vi && xi < 512) ? xi / 8 : 0;
        check("address", int'(address_a), ea);
        if (fsi) begin
            if (dcnt == DECAY_FRAMES - 1) begin
                dcnt = 0;
                for (int i = 0; i < 64; i++) if (pk[i] > 0) pk[i]--;
            end else begin
                dcnt++;
            end
        end
        if (prev_v && prev_x < 512 && prev_x % 8 == 0 && mag > pk[eb]) pk[eb] = mag;
        prev_x = xi; prev_y = yi; prev_v = vi;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                step(xx, yy, 1'b1, 1'b0);
    endtask

    task automatic random_block(input int n);
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        for (int i = 0; i < n; i++)
            step(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639)),
                 int'($urandom_range(0, 524)),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 39) == 0);
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_addr_a", int'(address_a), 0);
        check("rst_addr_b", int'(address_b), 0);
        check("rst_rgb_a", int'({r_a, g_a, b_a}), 0);
        check("rst_rgb_b", int'({r_b, g_b, b_b}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_addr", int'(address_a), 0);
        check("reset_rgb_a", int'({r_a, g_a, b_a}), 0);
        check("reset_rgb_b", int'({r_b, g_b, b_b}), 0);
        rst = 1'b0;

        // Zero-magnitude rows including blanking
        foreach (pk[k]) pk[k] = pk[k];
        for (int r = 0; r < 5; r++) begin
            int rows [5] = '{0, 100, 470, 471, 524};
            for (int xx = 0; xx < 800; xx++) step(xx, rows[r], xx < 640, 1'b0);
        end

        // Bar edges for bin 3 and baseline clamp for bin 0
        mem[3] = 8'd100;
        mem[0] = 8'd255;
        scan(20, 33, 368, 472);
        scan(0, 9, 195, 205);
        scan(0, 9, 468, 472);
        scan(508, 515, 469, 471);

        // Peak on bin 5 decaying over frames
        mem[5] = 8'd80;
        step(40, 0, 1'b1, 1'b0);
        step(41, 0, 1'b1, 1'b0);
        mem[5] = 8'd0;
        for (int f = 0; f < 12; f++) begin
            scan(41, 41, 384, 392);
            step(700, 0, 1'b0, 1'b1);
        end

        // Decay and update on bin 2 landing on the same cycle
        mem[2] = 8'd10;
        step(16, 0, 1'b1, 1'b0);
        step(17, 0, 1'b1, 1'b0);
        for (int k = 0; k < DECAY_FRAMES && dcnt != DECAY_FRAMES - 1; k++)
            step(700, 0, 1'b0, 1'b1);
        mem[2] = 8'd9;
        step(16, 460, 1'b1, 1'b0);
        step(17, 461, 1'b1, 1'b1);
        scan(17, 17, 455, 465);

        for (int blk = 0; blk < 8; blk++) random_block(600);
        mid_reset();
        random_block(600);
        mid_reset();
        random_block(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
